// File: rtl/fpu_issue_queue_if.sv
// fpu_issue_queue_if
// Bundles the two handshakes around the FPU issue queue:
//   cmd_*   : valid/ready channel from the issuing pipeline (operands + op code)
//   issue_* : rdy/ack channel towards the FPU input port
// Modports:
//   slave  : the queue itself (consumes cmd_*, produces issue_*)
//   master : the environment (producer pipeline plus FPU)
interface fpu_issue_queue_if #(
  parameter int bitness = 32
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [bitness-1:0] cmd_a;
  logic [bitness-1:0] cmd_b;
  logic [3:0]         cmd_op;

  logic               issue_rdy;
  logic               issue_ack;
  logic [bitness-1:0] issue_a;
  logic [bitness-1:0] issue_b;
  logic [3:0]         issue_op;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, issue_ack,
    input  cmd_ready, issue_rdy, issue_a, issue_b, issue_op
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, issue_ack,
    output cmd_ready, issue_rdy, issue_a, issue_b, issue_op
  );
endinterface

// File: rtl/fpu_issue_queue.sv
// fpu_issue_queue
// Operand/command FIFO placed in front of the FPU. Commands arrive over a
// valid/ready channel, are buffered in a depth-entry FIFO and handed to the
// FPU one at a time through an issue register using an rdy/ack handshake.
// A RELEASE state waits for ack to drop so a sticky ack cannot be mistaken
// for acceptance of the following command.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus          : fpu_issue_queue_if.slave (cmd_* in, issue_* out)
//   count        : entries held in the FIFO (issue register not included)
//   err_drop     : one-cycle pulse when a reserved-op command is discarded
// Optional feature macro: FPU_ISSUE_OP_CHECK_EN
//   defined   - commands with op >= 4 are accepted but dropped, err_drop pulses
//   undefined - every op code is queued; err_drop stays 0
module fpu_issue_queue #(
  parameter int bitness = 32,
  parameter int depth   = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  fpu_issue_queue_if.slave           bus,
  output logic [$clog2(depth+1)-1:0] count,
  output logic                       err_drop
);
  localparam int PW = $clog2(depth);
  localparam int CW = $clog2(depth+1);
  localparam int EW = 2*bitness + 4;
  localparam logic [CW-1:0] FULL_COUNT = CW'(depth);

  typedef enum logic [1:0] {IDLE, PRESENT, RELEASE} state_t;

  state_t             state_q, state_d;
  logic [EW-1:0]      mem_q [depth];
  logic [EW-1:0]      mem_d [depth];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [bitness-1:0] issue_a_q, issue_a_d;
  logic [bitness-1:0] issue_b_q, issue_b_d;
  logic [3:0]         issue_op_q, issue_op_d;
  logic               err_drop_q, err_drop_d;
  logic               push, write_en, pop;

  // Ready depends only on the registered count, so a pop in the same cycle
  // never lets a push into a full FIFO.
  assign bus.cmd_ready = !reset && (count_q != FULL_COUNT);
  assign push          = bus.cmd_valid && bus.cmd_ready;

`ifdef FPU_ISSUE_OP_CHECK_EN
  logic reserved_op;
  assign reserved_op = (bus.cmd_op[3:2] != 2'b00);
  // Reserved ops complete the handshake but never reach the FIFO.
  assign write_en    = push && !reserved_op;
  assign err_drop_d  = push && reserved_op;
`else
  assign write_en    = push;
  assign err_drop_d  = 1'b0;
`endif

  // Issue FSM. A pop is only requested with count_q > 0, so the head slot
  // read here can never be the slot being written this cycle.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (bus.issue_ack) state_d = RELEASE;
      end
      RELEASE: begin
        if (!bus.issue_ack) begin
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = PRESENT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO storage, pointers, occupancy and the issue register.
  always_comb begin
    mem_d      = mem_q;
    issue_a_d  = issue_a_q;
    issue_b_d  = issue_b_q;
    issue_op_d = issue_op_q;
    if (write_en) mem_d[wr_ptr_q] = {bus.cmd_op, bus.cmd_b, bus.cmd_a};
    wr_ptr_d = wr_ptr_q + PW'(write_en);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(write_en) - CW'(pop);
    if (pop) {issue_op_d, issue_b_d, issue_a_d} = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      issue_a_q  <= '0;
      issue_b_q  <= '0;
      issue_op_q <= '0;
      err_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      issue_a_q  <= issue_a_d;
      issue_b_q  <= issue_b_d;
      issue_op_q <= issue_op_d;
      err_drop_q <= err_drop_d;
    end
  end

  // Storage needs no reset: stale entries are unreachable once pointers clear.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign bus.issue_rdy = (state_q == PRESENT);
  assign bus.issue_a   = issue_a_q;
  assign bus.issue_b   = issue_b_q;
  assign bus.issue_op  = issue_op_q;
  assign count         = count_q;
  assign err_drop      = err_drop_q;
endmodule
